tdm_demux_4ch: RTL and testbench
================================

// Module: tdm_demux_4ch
// PURPOSE
//  Time-division demultiplexer: the receive end of a muxed channel link.
//  Accepts one WIDTH-bit word per valid beat, frame-aligned by a start-of-frame flag.
//  Routes beats in order to NCH channel slots and presents a complete frame in parallel.
//  Sits after the select-driven channel mux / serial link and feeds per-channel consumers.
// PARAMETERS
//  WIDTH   8   bits per channel word
//  NCH     4   channels per frame (>=2); slot index width CW = $clog2(NCH)
// PORTS
//  clk          in   1          single system clock, all logic on rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  din          in   WIDTH      channel word for the current beat
//  din_valid    in   1          din/sof qualified this cycle
//  sof          in   1          beat carries channel 0 (start of frame); ignored when din_valid=0
//  dout         out  NCH*WIDTH  last complete frame; ch k at [k*WIDTH +: WIDTH]
//  frame_valid  out  1          1-cycle pulse: dout just updated with a new frame
//  busy         out  1          1 while a frame is partially received (state RECV)
//  sync_err     out  1          1-cycle pulse: frame aborted by early sof
//  err_cnt      out  8          count of sync_err events, wraps 255->0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=HUNT, slot cnt=0, shadow regs=0, dout=0,
//   frame_valid=0, sync_err=0, err_cnt=0, busy=0. Takes effect immediately.
//  Reset mid-frame discards partial frame; dout returns to 0.
//  All outputs registered; no combinational din->out path.
//  Beat = rising edge with din_valid=1. Cycles with din_valid=0 change nothing
//   (state, cnt, shadow hold; pulses deassert).
//  FSM HUNT (waiting for frame start):
//   beat & sof  -> shadow[0]<=din, cnt<=1, go RECV.
//   beat & !sof -> word dropped, stay HUNT, no error.
//  FSM RECV (cnt = next slot, 1..NCH-1):
//   beat & !sof & cnt<NCH-1 -> shadow[cnt]<=din, cnt<=cnt+1.
//   beat & !sof & cnt==NCH-1 -> on this edge dout<={din,shadow[NCH-2:0]},
//     frame_valid<=1, cnt<=0, go HUNT. Latency: dout valid the cycle after last beat.
//   beat & sof (early, any cnt) -> sync_err<=1, err_cnt<=err_cnt+1, partial frame
//     discarded (dout unchanged), beat taken as new ch0: shadow[0]<=din, cnt<=1, stay RECV.
//  Back-to-back frames: sof on the beat right after the last beat is legal (state
//   already HUNT); frame_valid may pulse every NCH beats with no gap.
//  dout holds its value between frames; only changes on frame completion or reset.
//  busy = (state==RECV), registered.
//  err_cnt wraps modulo 256, no saturation.
//  Simultaneous completion and sof impossible (sof on a beat always means ch0).
// TESTING
//  1 Reset: rst_n=0 mid-sim -> dout=0, frame_valid=0, busy=0, err_cnt=0 same cycle.
//  2 Frame: beats A1(sof),B2,C3,D4 consecutive -> next cycle dout=32'hD4C3B2A1,
//    frame_valid high exactly 1 cycle, busy low.
//  3 Gaps: same frame with din_valid=0 for 3 cycles between each beat -> same dout,
//    one frame_valid pulse, dout unchanged during gaps.
//  4 Hunt: beats 11,22 without sof then 33(sof),44,55,66 -> dout=32'h66554433,
//    sync_err never asserts.
//  5 Early sof: 01(sof),02,AA(sof),BB,CC,DD -> sync_err pulse on AA,
//    err_cnt=1, then dout=32'hDDCCBBAA; dout unchanged before that.
//  6 Back-to-back: 3 frames continuous (12 beats) -> 3 frame_valid pulses 4 cycles apart;
//    256 forced early-sof errors -> err_cnt wraps to 0.

Source files
------------

// File: rtl/tdm_demux_4ch.sv
// Time-division demultiplexer: collects NCH sof-aligned beats into shadow slots and
// publishes the complete frame in parallel, flagging frames cut short by an early sof.
module tdm_demux_4ch #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 sof,
    output logic [NCH*WIDTH-1:0] dout,
    output logic                 frame_valid,
    output logic                 busy,
    output logic                 sync_err,
    output logic [7:0]           err_cnt
);

    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        StHunt,
        StRecv
    } state_e;

    state_e                          r_state;
    logic [CW-1:0]                   r_cnt;
    // Slots 0..NCH-2 only; the last word goes straight from din into dout.
    logic [NCH-2:0][WIDTH-1:0]       r_shadow;
    logic [NCH*WIDTH-1:0]            r_dout;
    logic                            r_frame_valid;
    logic                            r_busy;
    logic                            r_sync_err;
    logic [7:0]                      r_err_cnt;

    logic                            w_last_slot;

    assign w_last_slot = (r_cnt == CW'(NCH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StHunt;
            r_cnt         <= '0;
            r_shadow      <= '0;
            r_dout        <= '0;
            r_frame_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_sync_err    <= 1'b0;
            r_err_cnt     <= 8'd0;
        end else begin
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            if (din_valid) begin
                unique case (r_state)
                    StHunt: begin
                        // Words seen before the first sof are dropped silently.
                        if (sof) begin
                            r_shadow[0] <= din;
                            r_cnt       <= CW'(1);
                            r_state     <= StRecv;
                            r_busy      <= 1'b1;
                        end
                    end
                    StRecv: begin
                        if (sof) begin
                            // Early sof: drop the partial frame and restart on this beat.
                            r_sync_err  <= 1'b1;
                            r_err_cnt   <= r_err_cnt + 8'd1;
                            r_shadow[0] <= din;
                            r_cnt       <= CW'(1);
                        end else if (w_last_slot) begin
                            r_dout        <= {din, r_shadow};
                            r_frame_valid <= 1'b1;
                            r_cnt         <= '0;
                            r_state       <= StHunt;
                            r_busy        <= 1'b0;
                        end else begin
                            r_shadow[r_cnt] <= din;
                            r_cnt           <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_state <= StHunt;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dout        = r_dout;
    assign frame_valid = r_frame_valid;
    assign busy        = r_busy;
    assign sync_err    = r_sync_err;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed bench for tdm_demux_4ch: inputs change and outputs are sampled on the falling edge.
module tb_tdm_demux_4ch;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_valid;
    logic        sof;
    logic [31:0] dout;
    logic        frame_valid;
    logic        busy;
    logic        sync_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    tdm_demux_4ch #(
        .WIDTH(8),
        .NCH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .dout       (dout),
        .frame_valid(frame_valid),
        .busy       (busy),
        .sync_err   (sync_err),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One beat: present at a falling edge, captured on the next rising edge.
    task automatic beat(input logic [7:0] d, input logic s);
        din       = d;
        sof       = s;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        sof       = 1'b0;
        idle(2);
        chk("rst_dout", dout, 32'h0);
        chk("rst_fv", {31'b0, frame_valid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_serr", {31'b0, sync_err}, 32'h0);
        chk("rst_errcnt", {24'b0, err_cnt}, 32'h0);
        rst_n = 1'b1;
        idle(1);

        // Basic frame
        beat(8'hA1, 1'b1);
        chk("t2_busy_a", {31'b0, busy}, 32'h1);
        beat(8'hB2, 1'b0);
        beat(8'hC3, 1'b0);
        chk("t2_fv_early", {31'b0, frame_valid}, 32'h0);
        beat(8'hD4, 1'b0);
        chk("t2_dout", dout, 32'hD4C3B2A1);
        chk("t2_fv", {31'b0, frame_valid}, 32'h1);
        chk("t2_busy", {31'b0, busy}, 32'h0);
        idle(1);
        chk("t2_fv_drop", {31'b0, frame_valid}, 32'h0);
        chk("t2_hold", dout, 32'hD4C3B2A1);

        // Same frame shape with 3 idle cycles between beats
        beat(8'h11, 1'b1);
        idle(3);
        chk("t3_gap1", dout, 32'hD4C3B2A1);
        chk("t3_busy", {31'b0, busy}, 32'h1);
        beat(8'h22, 1'b0);
        idle(3);
        chk("t3_gap2_fv", {31'b0, frame_valid}, 32'h0);
        beat(8'h33, 1'b0);
        idle(3);
        chk("t3_gap3", dout, 32'hD4C3B2A1);
        beat(8'h44, 1'b0);
        chk("t3_dout", dout, 32'h44332211);
        chk("t3_fv", {31'b0, frame_valid}, 32'h1);
        idle(3);
        chk("t3_fv_once", {31'b0, frame_valid}, 32'h0);

        // Hunt: words before sof are dropped without error
        beat(8'h11, 1'b0);
        chk("t4_hunt_busy", {31'b0, busy}, 32'h0);
        chk("t4_hunt_serr", {31'b0, sync_err}, 32'h0);
        beat(8'h22, 1'b0);
        chk("t4_hunt_dout", dout, 32'h44332211);
        beat(8'h33, 1'b1);
        beat(8'h44, 1'b0);
        beat(8'h55, 1'b0);
        chk("t4_serr", {31'b0, sync_err}, 32'h0);
        beat(8'h66, 1'b0);
        chk("t4_dout", dout, 32'h66554433);
        chk("t4_errcnt", {24'b0, err_cnt}, 32'h0);

        // Early sof aborts the partial frame
        beat(8'h01, 1'b1);
        beat(8'h02, 1'b0);
        beat(8'hAA, 1'b1);
        chk("t5_serr", {31'b0, sync_err}, 32'h1);
        chk("t5_errcnt", {24'b0, err_cnt}, 32'h1);
        chk("t5_busy", {31'b0, busy}, 32'h1);
        chk("t5_hold", dout, 32'h66554433);
        beat(8'hBB, 1'b0);
        chk("t5_serr_drop", {31'b0, sync_err}, 32'h0);
        beat(8'hCC, 1'b0);
        chk("t5_hold2", dout, 32'h66554433);
        beat(8'hDD, 1'b0);
        chk("t5_dout", dout, 32'hDDCCBBAA);
        chk("t5_fv", {31'b0, frame_valid}, 32'h1);

        // Back-to-back: three frames, no gaps
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 4; b++) begin
                beat(8'((f << 4) | b | 8'h80), (b == 0));
                chk($sformatf("t6_fv_f%0d_b%0d", f, b), {31'b0, frame_valid},
                    (b == 3) ? 32'h1 : 32'h0);
            end
            chk($sformatf("t6_dout_f%0d", f), dout,
                {8'(8'h83 | (f << 4)), 8'(8'h82 | (f << 4)),
                 8'(8'h81 | (f << 4)), 8'(8'h80 | (f << 4))});
        end

        // err_cnt is 1 here; 255 more early sofs wrap it to 0
        beat(8'h5A, 1'b1);
        for (int i = 0; i < 254; i++) beat(8'h5A, 1'b1);
        chk("t6_errcnt_255", {24'b0, err_cnt}, 32'hFF);
        beat(8'h5A, 1'b1);
        chk("t6_errcnt_wrap", {24'b0, err_cnt}, 32'h0);
        chk("t6_serr_wrap", {31'b0, sync_err}, 32'h1);
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b0);
        chk("t6_after_wrap", dout, 32'h0302015A);

        // Asynchronous reset mid-frame
        beat(8'h77, 1'b1);
        beat(8'h88, 1'b0);
        beat(8'h99, 1'b1);
        chk("t1_pre_errcnt", {24'b0, err_cnt}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_dout", dout, 32'h0);
        chk("t1_fv", {31'b0, frame_valid}, 32'h0);
        chk("t1_busy", {31'b0, busy}, 32'h0);
        chk("t1_errcnt", {24'b0, err_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(8'h10, 1'b0);
        chk("t1_partial_gone", {31'b0, busy}, 32'h0);
        beat(8'hE1, 1'b1);
        beat(8'hE2, 1'b0);
        beat(8'hE3, 1'b0);
        beat(8'hE4, 1'b0);
        chk("t1_recover", dout, 32'hE4E3E2E1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
